// File: rtl/uart_pkg.sv
// Shared definitions for the PDU UART path: frame geometry and the state
// encoding used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int DEFAULT_BIT_CYCLES = 435;

    typedef enum logic [2:0] {
        UART_DISABLED = 3'd0,
        UART_IDLE     = 3'd1,
        UART_START    = 3'd2,
        UART_BITS     = 3'd3,
        UART_STOP     = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the UART transmitter. The head entry is
// visible combinationally so the FSM can load it on the same edge it pops.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             flush;
    logic             do_push;
    logic             do_pop;

    assign flush   = rst | ~en;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push & ~do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop & ~do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push & ~flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes enter a FIFO over valid/ready and are shifted
// out LSB first, each bit held for exactly BIT_CYCLES clocks.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       uart_txd,
    output logic       busy
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

    uart_state_t               state;
    uart_state_t               state_next;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_next;
    logic [IDX_W-1:0]          bit_idx;
    logic [IDX_W-1:0]          bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_next;
    logic                      txd_next;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_head;
    logic                      bit_done;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready = (state != UART_DISABLED) & ~fifo_full;
    assign push     = in_valid & in_ready;
    assign busy     = (state == UART_START) | (state == UART_BITS) |
                      (state == UART_STOP) | ~fifo_empty;
    assign bit_done = (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst | ~en) begin
            state    <= UART_DISABLED;
            count    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_next;
            count    <= count_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            uart_txd <= txd_next;
        end
    end

    // The line value for the next bit is registered one edge ahead, so every
    // bit (start and stop included) lasts exactly BIT_CYCLES clocks.
    always_comb begin
        state_next   = state;
        count_next   = count;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        txd_next     = uart_txd;
        pop          = 1'b0;

        case (state)
            UART_DISABLED: begin
                txd_next   = 1'b1;
                state_next = UART_IDLE;
            end
            UART_IDLE: begin
                txd_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    txd_next   = 1'b0;
                    count_next = '0;
                    state_next = UART_START;
                end
            end
            UART_START: begin
                if (bit_done) begin
                    count_next   = '0;
                    txd_next     = shift[0];
                    shift_next   = {1'b0, shift[UART_DATA_BITS-1:1]};
                    bit_idx_next = '0;
                    state_next   = UART_BITS;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            UART_BITS: begin
                if (bit_done) begin
                    count_next = '0;
                    if (bit_idx == LAST_IDX) begin
                        txd_next   = 1'b1;
                        state_next = UART_STOP;
                    end else begin
                        txd_next     = shift[0];
                        shift_next   = {1'b0, shift[UART_DATA_BITS-1:1]};
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    count_next = count + 1'b1;
                end
            end
            UART_STOP: begin
                if (bit_done) begin
                    count_next = '0;
                    state_next = UART_IDLE;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                txd_next   = 1'b1;
                state_next = UART_DISABLED;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a full-rate instance (435 cycles/bit) for frame shape and
// a fast instance (4 cycles/bit) for FIFO, abort and back-to-back corners.
module tb_uart_tx;

    localparam int SLOW_BC = 435;
    localparam int FAST_BC = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_s, en_f;
    logic       valid_s, valid_f;
    logic [7:0] data_s, data_f;
    logic       ready_s, ready_f;
    logic       txd_s, txd_f;
    logic       busy_s, busy_f;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t expq[$];

    always #5 clk = ~clk;

    uart_tx #(.BIT_CYCLES(SLOW_BC), .FIFO_DEPTH(4)) dut_slow (
        .clk(clk), .rst(rst), .en(en_s), .in_valid(valid_s), .in_data(data_s),
        .in_ready(ready_s), .uart_txd(txd_s), .busy(busy_s)
    );

    uart_tx #(.BIT_CYCLES(FAST_BC), .FIFO_DEPTH(4)) dut_fast (
        .clk(clk), .rst(rst), .en(en_f), .in_valid(valid_f), .in_data(data_f),
        .in_ready(ready_f), .uart_txd(txd_f), .busy(busy_f)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; the transfer happens on the following posedge and
    // the task returns at the negedge after it.
    task automatic push_byte(input bit slow, input logic [7:0] b);
        if (slow) begin
            valid_s = 1'b1;
            data_s  = b;
            check_output($sformatf("in_ready before push 0x%02h", b), ready_s, 1);
        end else begin
            valid_f = 1'b1;
            data_f  = b;
            check_output($sformatf("in_ready before push 0x%02h", b), ready_f, 1);
        end
        @(posedge clk);
        @(negedge clk);
        if (slow) begin
            valid_s = 1'b0;
            data_s  = ~b;
        end else begin
            valid_f = 1'b0;
            data_f  = ~b;
        end
    endtask

    // Checks one whole frame cycle by cycle and decodes it by mid-bit sampling.
    task automatic expect_frame(input bit slow, input int bc, input logic [9:0] frame,
                                input string name, output logic [7:0] decoded);
        int   match_cnt;
        int   busy_cnt;
        logic t;
        busy_cnt = 0;
        decoded  = '0;
        for (int i = 0; i < 10; i++) begin
            match_cnt = 0;
            for (int c = 0; c < bc; c++) begin
                @(negedge clk);
                t = slow ? txd_s : txd_f;
                if (t === frame[i]) match_cnt++;
                if ((slow ? busy_s : busy_f) === 1'b1) busy_cnt++;
                if (c == bc / 2 && i >= 1 && i <= 8) decoded[i-1] = t;
            end
            check_output($sformatf("%s bit%0d cycles matching", name, i), match_cnt, bc);
        end
        check_output($sformatf("%s busy cycles", name), busy_cnt, 10 * bc);
    endtask

    // Drains expq, expecting frames at a pitch of 10*bc+1 starting one cycle
    // after the first push edge.
    task automatic monitor_frames(input bit slow, input int bc, input string tag);
        logic [7:0] dec;
        vec_t       v;
        int         k;
        k = 0;
        @(negedge clk);
        check_output({tag, " line idle on accept cycle"}, slow ? txd_s : txd_f, 1);
        while (expq.size() > 0) begin
            v = expq.pop_front();
            if (k > 0) begin
                @(negedge clk);
                check_output($sformatf("%s idle gap before frame%0d", tag, k),
                             slow ? txd_s : txd_f, 1);
            end
            expect_frame(slow, bc, v.frame, $sformatf("%s frame%0d", tag, k), dec);
            check_output($sformatf("%s frame%0d decoded byte", tag, k), dec, v.data);
            k++;
        end
        @(negedge clk);
        check_output({tag, " busy clear after stop"}, slow ? busy_s : busy_f, 0);
    endtask

    task automatic expect_quiet_line(input string tag, input int cycles);
        int quiet;
        quiet = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (txd_f === 1'b1 && busy_f === 1'b0) quiet++;
        end
        check_output({tag, " quiet cycles"}, quiet, cycles);
    endtask

    initial begin
        vec_t slow_vecs[4];
        vec_t burst[5];
        vec_t same_edge[6];

        slow_vecs[0] = '{8'h55, 10'h2AA};
        slow_vecs[1] = '{8'hA5, 10'h34A};
        slow_vecs[2] = '{8'h00, 10'h200};
        slow_vecs[3] = '{8'hFF, 10'h3FE};

        burst[0] = '{8'h01, 10'h202};
        burst[1] = '{8'h02, 10'h204};
        burst[2] = '{8'h03, 10'h206};
        burst[3] = '{8'h04, 10'h208};
        burst[4] = '{8'h05, 10'h20A};

        same_edge[0] = '{8'hC3, 10'h386};
        same_edge[1] = '{8'h5A, 10'h2B4};
        same_edge[2] = '{8'h81, 10'h302};
        same_edge[3] = '{8'h7E, 10'h2FC};
        same_edge[4] = '{8'h00, 10'h200};
        same_edge[5] = '{8'hFF, 10'h3FE};

        rst = 1'b1; en_s = 1'b1; en_f = 1'b1;
        valid_s = 1'b0; valid_f = 1'b0; data_s = '0; data_f = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset txd", txd_f, 1);
        check_output("reset busy", busy_f, 0);
        check_output("reset in_ready", ready_f, 0);
        check_output("reset in_ready slow", ready_s, 0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle in_ready", ready_f, 1);
        check_output("idle busy", busy_f, 0);
        check_output("idle txd", txd_f, 1);

        // Full-rate frames, one at a time.
        for (int i = 0; i < 4; i++) begin
            expq.push_back(slow_vecs[i]);
            fork
                push_byte(1'b1, slow_vecs[i].data);
                monitor_frames(1'b1, SLOW_BC, $sformatf("slow%0d", i));
            join
        end

        // Continuous burst of five bytes into a four-entry FIFO.
        foreach (burst[i]) expq.push_back(burst[i]);
        fork
            begin
                for (int i = 0; i < 5; i++) push_byte(1'b0, burst[i].data);
                check_output("burst in_ready when full", ready_f, 0);
                repeat (37) @(negedge clk);
                check_output("burst in_ready before 0x02 pop", ready_f, 0);
                @(negedge clk);
                check_output("burst in_ready after 0x02 pop", ready_f, 1);
            end
            monitor_frames(1'b0, FAST_BC, "burst");
        join

        // Push lands on the same edge as a pop with two entries queued.
        foreach (same_edge[i]) expq.push_back(same_edge[i]);
        fork
            begin
                for (int i = 0; i < 3; i++) push_byte(1'b0, same_edge[i].data);
                repeat (39) @(negedge clk);
                for (int i = 3; i < 6; i++) push_byte(1'b0, same_edge[i].data);
                check_output("same-edge count: full after two more", ready_f, 0);
            end
            monitor_frames(1'b0, FAST_BC, "same_edge");
        join

        // Enable dropped during data bit 3.
        push_byte(1'b0, 8'h00);
        push_byte(1'b0, 8'h3C);
        repeat (17) @(negedge clk);
        check_output("en-drop pre txd (bit3 low)", txd_f, 0);
        en_f = 1'b0;
        @(negedge clk);
        check_output("en-drop txd", txd_f, 1);
        check_output("en-drop busy", busy_f, 0);
        check_output("en-drop in_ready", ready_f, 0);
        en_f = 1'b1;
        @(negedge clk);
        check_output("en-restore in_ready", ready_f, 1);
        check_output("en-restore busy", busy_f, 0);
        expect_quiet_line("en-restore", 3 * FAST_BC);

        // Reset during the stop bit with two bytes queued.
        push_byte(1'b0, 8'hA5);
        push_byte(1'b0, 8'h12);
        push_byte(1'b0, 8'h34);
        repeat (36) @(negedge clk);
        check_output("stop-rst pre txd", txd_f, 1);
        check_output("stop-rst pre busy", busy_f, 1);
        rst = 1'b1;
        @(negedge clk);
        check_output("stop-rst txd", txd_f, 1);
        check_output("stop-rst busy", busy_f, 0);
        check_output("stop-rst in_ready", ready_f, 0);
        rst = 1'b0;
        @(negedge clk);
        check_output("stop-rst release in_ready", ready_f, 1);
        expect_quiet_line("stop-rst", 3 * FAST_BC);
        expq.push_back('{8'h3C, 10'h278});
        fork
            push_byte(1'b0, 8'h3C);
            monitor_frames(1'b0, FAST_BC, "after-rst");
        join

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter, the transmit-side companion to the existing 115200 receiver on the PDU UART path.
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte as start bit, 8 data bits LSB first, then a stop bit on uart_txd.
- Same clock and bit period as the receiver, so TX→RX loopback is exact.

Parameters:
BIT_CYCLES, 435, clk cycles per UART bit (115200 baud at the PDU clock; matches the receiver's 0..434 bit count).
FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
en  in  1  enable; low behaves as reset (flush, abort, line idle).
in_valid  in  1  in_data holds a byte to send.
in_data  in  8  byte to send.
in_ready  out  1  FIFO can accept; a transfer happens when in_valid & in_ready at a clk edge.
uart_txd  out  1  serial line, registered, idle high.
busy  out  1  high while a frame is in progress or the FIFO is non-empty.

Behaviour:
- Reset/disable: when rst | ~en at a clk edge, the following hold at the next edge:
  - state DISABLED; uart_txd=1; FIFO empty; busy=0; in_ready=0.
  - internal counter, bit index and shift register cleared.
- Mid-frame rst or en drop aborts the frame. The line returns high at the next edge with no partial stop bit.
- States:
  - DISABLED → IDLE unconditionally on the next edge once rst=0 and en=1.
  - IDLE: uart_txd=1. If the FIFO is non-empty, in one edge: pop head into shift, uart_txd<=0, counter<=0, state<=START.
  - START: counter increments each cycle. At counter==BIT_CYCLES-1: counter<=0, uart_txd<=shift[0], shift>>=1, bit index<=0, state<=BITS.
  - BITS: at counter==BIT_CYCLES-1: counter<=0.
    - If bit index==7: uart_txd<=1, state<=STOP.
    - Otherwise: uart_txd<=shift[0], shift>>=1, bit index increments.
  - STOP: at counter==BIT_CYCLES-1, state<=IDLE.
  - Illegal state encoding → DISABLED.
- Timing:
  - Every bit, start and stop included, is exactly BIT_CYCLES cycles.
  - Byte accepted at edge N into an empty FIFO with the FSM in IDLE: uart_txd falls at edge N+1.
  - Back-to-back frames: stop bit is BIT_CYCLES cycles, plus 1 IDLE cycle before the next start. Frame pitch is 10*BIT_CYCLES+1.
- Handshake:
  - in_ready = (state != DISABLED) & ~fifo_full, combinational from registered state/count.
  - in_data is captured only on the transfer edge.
- FIFO boundaries:
  - Push and pop on the same edge when not full: both take effect, count unchanged.
  - When full, in_ready=0, so no push. A same-edge pop frees a slot, visible as in_ready=1 the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- busy = (state in START/BITS/STOP) | fifo_nonempty.
- Counter width: clog2(BIT_CYCLES). No other arithmetic.

Decomposition:
- Shared package uart_pkg:
  - state encodings (DISABLED/IDLE/START/BITS/STOP) for TX and RX;
  - UART_DATA_BITS=8;
  - default BIT_CYCLES.
- Sub-module uart_tx_fifo:
  - parameterised synchronous FIFO: push/pop/full/empty/head, flush on rst|~en;
  - first-word head is combinational.
- The FSM and shifter stay in uart_tx.

Test Plan:
- BIT_CYCLES=435: send 0x55 → txd low 435 cycles, then 1,0,1,0,1,0,1,0 each 435 cycles, then high. Falling edge 1 cycle after acceptance; busy clears at STOP end.
- BIT_CYCLES=4, FIFO_DEPTH=4, FSM sending: push 0x01,0x02,0x03,0x04,0x05 continuously → 0x01 popped immediately; 0x02–0x05 fill the FIFO; in_ready=0 until 0x02 is popped. All five frames emitted in order, pitch 41 cycles.
- Loopback into the existing receiver, same clk, BIT_CYCLES=435: send 0xA5, 0x00, 0xFF → receiver ready pulses with data 0xA5, 0x00, 0xFF.
- en dropped at BITS bit index 3 → next edge txd=1, busy=0, in_ready=0, FIFO empty. On en re-assert: one DISABLED cycle, then in_ready=1.
- rst asserted during STOP with 2 bytes queued → txd=1, FIFO empty, no further frames. After release, a new 0x3C is sent correctly.
- Push and pop on the same edge with FIFO count 2 → count stays 2, no data loss, output order preserved.
